// File: rtl/stim_gen_pkg.sv
// Shared constants for the stimulus pulse generator: register map, CTRL bits,
// FSM encoding and LFSR seed.
package stim_gen_pkg;

  localparam logic [2:0] A_CTRL   = 3'd0;
  localparam logic [2:0] A_DELAY  = 3'd1;
  localparam logic [2:0] A_WIDTH  = 3'd2;
  localparam logic [2:0] A_COUNT  = 3'd3;
  localparam logic [2:0] A_RMASK  = 3'd4;
  localparam logic [2:0] A_STATUS = 3'd5;
  localparam logic [2:0] A_REMAIN = 3'd6;

  localparam int CTRL_START  = 0;
  localparam int CTRL_STOP   = 1;
  localparam int CTRL_CONT   = 2;
  localparam int CTRL_IRQ_EN = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_PULSE = 2'd2
  } state_e;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

endpackage

// File: rtl/stim_lfsr.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11), seeded at reset, used to jitter
// the inter-pulse delay.
module stim_lfsr
  import stim_gen_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en_i,
  output logic [15:0] lfsr_o
);

  logic [15:0] lfsr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    lfsr_q <= LFSR_SEED;
    else if (en_i) lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/logicalstep_stimulus_gen.sv
// Avalon-MM programmable stimulus pulse generator (delay / width / repeat).
// Optional random delay jitter is enabled by defining STIM_RANDOM_DELAY_EN.
module logicalstep_stimulus_gen
  import stim_gen_pkg::*;
#(
  parameter int TICK_DIV = 50000,
  parameter int DELAY_W  = 16,
  parameter int WIDTH_W  = 16,
  parameter int COUNT_W  = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        stim_out,
  output logic        irq
);

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CNT_W = (DELAY_W > WIDTH_W) ? DELAY_W : WIDTH_W;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q, dload;
  logic [PRE_W-1:0]   pre_q;
  logic [COUNT_W-1:0] remain_q, count_q;
  logic [DELAY_W-1:0] delay_q;
  logic [WIDTH_W-1:0] width_q;
  logic               stim_q, done_q, cont_q, irq_en_q;
  logic [31:0]        rdata_q, rdata_d;
  logic               wr, ctrl_wr, start_w, stop_w, sts_clr, tick, busy;
  logic               unused_wd;

  assign wr      = chipselect & ~write_n;
  assign ctrl_wr = wr && (address == A_CTRL);
  assign stop_w  = ctrl_wr && writedata[CTRL_STOP];
  assign start_w = ctrl_wr && writedata[CTRL_START] && !writedata[CTRL_STOP];
  assign sts_clr = wr && (address == A_STATUS);
  assign tick    = (pre_q == PRE_W'(TICK_DIV - 1));
  assign busy    = (state_q != ST_IDLE);
  assign unused_wd = ^writedata;

`ifdef STIM_RANDOM_DELAY_EN
  localparam int SUM_W = ((DELAY_W > 16) ? DELAY_W : 16) + 1;
  localparam logic [SUM_W-1:0] DSAT = SUM_W'({DELAY_W{1'b1}});
  logic [15:0]      lfsr, rmask_q;
  logic [SUM_W-1:0] dsum;

  stim_lfsr u_lfsr (.clk(clk), .rst_n(reset_n), .en_i(1'b1), .lfsr_o(lfsr));

  // Jittered delay saturates rather than wrapping to a short delay.
  assign dsum  = SUM_W'(delay_q) + SUM_W'(lfsr & rmask_q);
  assign dload = CNT_W'((dsum > DSAT) ? DSAT : dsum);
`else
  assign dload = CNT_W'(delay_q);
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      delay_q  <= '0;
      width_q  <= '0;
      count_q  <= '0;
      cont_q   <= 1'b0;
      irq_en_q <= 1'b0;
`ifdef STIM_RANDOM_DELAY_EN
      rmask_q  <= '0;
`endif
    end else if (wr) begin
      case (address)
        A_CTRL: begin
          cont_q   <= writedata[CTRL_CONT];
          irq_en_q <= writedata[CTRL_IRQ_EN];
        end
        A_DELAY: delay_q <= writedata[DELAY_W-1:0];
        A_WIDTH: width_q <= writedata[WIDTH_W-1:0];
        A_COUNT: count_q <= writedata[COUNT_W-1:0];
`ifdef STIM_RANDOM_DELAY_EN
        A_RMASK: rmask_q <= writedata[15:0];
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      pre_q    <= '0;
      remain_q <= '0;
      stim_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      pre_q <= (state_q == ST_IDLE || tick) ? '0 : pre_q + PRE_W'(1);
      if (sts_clr) done_q <= 1'b0;
      if (stop_w) begin
        state_q  <= ST_IDLE;
        stim_q   <= 1'b0;
        remain_q <= '0;
        cnt_q    <= '0;
        pre_q    <= '0;
      end else begin
        case (state_q)
          ST_IDLE: if (start_w) begin
            state_q  <= ST_WAIT;
            cnt_q    <= dload;
            pre_q    <= '0;
            remain_q <= (count_q == '0) ? COUNT_W'(1) : count_q;
          end
          ST_WAIT: if (cnt_q == '0) begin
            state_q <= ST_PULSE;
            stim_q  <= 1'b1;
            pre_q   <= '0;
            cnt_q   <= (width_q == '0) ? CNT_W'(1) : CNT_W'(width_q);
          end else if (tick) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
          ST_PULSE: if (cnt_q == '0) begin
            stim_q <= 1'b0;
            pre_q  <= '0;
            if (!cont_q && remain_q != '0) remain_q <= remain_q - COUNT_W'(1);
            if (cont_q || remain_q > COUNT_W'(1)) begin
              state_q <= ST_WAIT;
              cnt_q   <= dload;
            end else begin
              state_q <= ST_IDLE;
              done_q  <= 1'b1;  // placed after the clear so a same-cycle set wins
            end
          end else if (tick) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    rdata_d = '0;
    case (address)
      A_CTRL: begin
        rdata_d[0]           = busy;
        rdata_d[CTRL_CONT]   = cont_q;
        rdata_d[CTRL_IRQ_EN] = irq_en_q;
      end
      A_DELAY:  rdata_d[DELAY_W-1:0] = delay_q;
      A_WIDTH:  rdata_d[WIDTH_W-1:0] = width_q;
      A_COUNT:  rdata_d[COUNT_W-1:0] = count_q;
`ifdef STIM_RANDOM_DELAY_EN
      A_RMASK:  rdata_d[15:0]        = rmask_q;
`endif
      A_STATUS: rdata_d[0]           = done_q;
      A_REMAIN: rdata_d[COUNT_W-1:0] = remain_q;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rdata_q <= '0;
    else          rdata_q <= rdata_d;
  end

  assign readdata = rdata_q;
  assign stim_out = stim_q;
  assign irq      = done_q & irq_en_q;

endmodule
